// File: rtl/udma_mram_cmd_seq.sv
// Command sequencer for the MRAM macro wrapper: single read/program/erase requests in, pin sequencing out.
// Optional ECC status capture on reads is enabled by defining MRAM_ECC_STATUS_EN.
module udma_mram_cmd_seq #(
  parameter int unsigned READ_LAT    = 2,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [18:0] req_addr_i,
  input  logic [77:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [77:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_ec_o,
  output logic        rsp_ue_o,
  output logic        busy_o,
  output logic        mram_CEb_o,
  output logic        mram_WEb_o,
  output logic        mram_RDEN_o,
  output logic        mram_PROGEN_o,
  output logic        mram_PROG_o,
  output logic        mram_ERASE_o,
  output logic        mram_CHIP_o,
  output logic [18:0] mram_A_o,
  output logic [77:0] mram_DIN_o,
  input  logic [77:0] mram_DOUT_i,
  input  logic        mram_RDY_i,
  input  logic        mram_DONE_i,
  input  logic        mram_EC_i,
  input  logic        mram_UE_i
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_PG_SETUP,
    S_PG_PULSE,
    S_PG_WAIT,
    S_ER_PULSE,
    S_ER_WAIT,
    S_RESP
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  lat_q, lat_d;
  logic [19:0] tmo_q, tmo_d;
  logic [18:0] addr_q, addr_d;
  logic [77:0] din_q, din_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [77:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ec_q, ec_d;
  logic        ue_q, ue_d;
  logic        busy_q, busy_d;
  logic        ceb_q, ceb_d;
  logic        web_q, web_d;
  logic        rden_q, rden_d;
  logic        progen_q, progen_d;
  logic        prog_q, prog_d;
  logic        erase_q, erase_d;
  logic        chip_q, chip_d;

  logic accept;
  logic done_ok;
  logic tmo_exp;

  always_comb begin
    accept  = (state_q == S_IDLE) && req_valid_i && mram_RDY_i;
    done_ok = mram_DONE_i && mram_RDY_i;
    // The counter expires on the cycle its decrement would reach zero.
    tmo_exp = (tmo_q <= 20'd1);

    state_d = state_q;
    op_d    = op_q;
    lat_d   = lat_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ec_d    = ec_q;
    ue_d    = ue_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = req_op_i;
          addr_d = req_addr_i;
          din_d  = req_wdata_i;
          tmo_d  = TIMEOUT_CYC;
          case (req_op_i)
            2'b00:   state_d = S_RD_ISSUE;
            2'b01:   state_d = S_PG_SETUP;
            default: state_d = S_ER_PULSE;
          endcase
        end
      end
      S_RD_ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == 3'd0) begin
          rdata_d = mram_DOUT_i;
`ifdef MRAM_ECC_STATUS_EN
          ec_d    = mram_EC_i;
          ue_d    = mram_UE_i;
          err_d   = mram_UE_i;
`else
          ec_d    = 1'b0;
          ue_d    = 1'b0;
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end else if (tmo_exp) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ec_d    = 1'b0;
          ue_d    = 1'b0;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - 3'd1;
          tmo_d = tmo_q - 20'd1;
        end
      end
      S_PG_SETUP: state_d = S_PG_PULSE;
      S_PG_PULSE: state_d = S_PG_WAIT;
      S_ER_PULSE: state_d = S_ER_WAIT;
      S_PG_WAIT, S_ER_WAIT: begin
        // Completion wins over a same-cycle timeout.
        if (done_ok) begin
          rdata_d = '0;
          err_d   = 1'b0;
          ec_d    = 1'b0;
          ue_d    = 1'b0;
          state_d = S_RESP;
        end else if (tmo_exp) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ec_d    = 1'b0;
          ue_d    = 1'b0;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q - 20'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);

    // Pins are decoded from the state being entered so they register alongside it.
    ceb_d    = 1'b1;
    web_d    = 1'b1;
    rden_d   = 1'b0;
    progen_d = 1'b0;
    prog_d   = 1'b0;
    erase_d  = 1'b0;
    chip_d   = 1'b0;
    case (state_d)
      S_RD_ISSUE: begin
        ceb_d  = 1'b0;
        rden_d = 1'b1;
      end
      S_RD_WAIT: ceb_d = 1'b0;
      S_PG_SETUP, S_PG_WAIT, S_ER_WAIT: begin
        ceb_d    = 1'b0;
        progen_d = 1'b1;
      end
      S_PG_PULSE: begin
        ceb_d    = 1'b0;
        progen_d = 1'b1;
        web_d    = 1'b0;
        prog_d   = 1'b1;
      end
      S_ER_PULSE: begin
        ceb_d    = 1'b0;
        progen_d = 1'b1;
        erase_d  = 1'b1;
        chip_d   = (op_d == 2'b11);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      lat_q       <= 3'd0;
      tmo_q       <= 20'd0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ec_q        <= 1'b0;
      ue_q        <= 1'b0;
      busy_q      <= 1'b0;
      ceb_q       <= 1'b1;
      web_q       <= 1'b1;
      rden_q      <= 1'b0;
      progen_q    <= 1'b0;
      prog_q      <= 1'b0;
      erase_q     <= 1'b0;
      chip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lat_q       <= lat_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ec_q        <= ec_d;
      ue_q        <= ue_d;
      busy_q      <= busy_d;
      ceb_q       <= ceb_d;
      web_q       <= web_d;
      rden_q      <= rden_d;
      progen_q    <= progen_d;
      prog_q      <= prog_d;
      erase_q     <= erase_d;
      chip_q      <= chip_d;
    end
  end

  assign req_ready_o   = (state_q == S_IDLE) && mram_RDY_i;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign busy_o        = busy_q;
  assign mram_CEb_o    = ceb_q;
  assign mram_WEb_o    = web_q;
  assign mram_RDEN_o   = rden_q;
  assign mram_PROGEN_o = progen_q;
  assign mram_PROG_o   = prog_q;
  assign mram_ERASE_o  = erase_q;
  assign mram_CHIP_o   = chip_q;
  assign mram_A_o      = addr_q;
  assign mram_DIN_o    = din_q;

`ifdef MRAM_ECC_STATUS_EN
  assign rsp_ec_o = ec_q;
  assign rsp_ue_o = ue_q;
`else
  logic unused_ecc;
  assign unused_ecc = mram_EC_i ^ mram_UE_i ^ ec_q ^ ue_q;
  assign rsp_ec_o   = 1'b0;
  assign rsp_ue_o   = 1'b0;
`endif

endmodule

// File: tb/tb_udma_mram_cmd_seq.sv
// Directed bench for udma_mram_cmd_seq: instance "dut" (default timeout) and "dut_b" (TIMEOUT_CYC=16).
`timescale 1ns/1ps
module tb_udma_mram_cmd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        req_valid, req_valid_b;
  logic [1:0]  req_op;
  logic [18:0] req_addr;
  logic [77:0] req_wdata;
  logic        rsp_ready;
  logic        rdy, done, ec_in, ue_in;
  logic [77:0] dout;
  logic [77:0] rd_val;

  logic        req_ready, rsp_valid, rsp_err, rsp_ec, rsp_ue, busy;
  logic [77:0] rsp_rdata, din;
  logic [18:0] addr;
  logic        ceb, web, rden, progen, prog, erase, chip;

  logic        req_ready_b, rsp_valid_b, rsp_err_b, rsp_ec_b, rsp_ue_b, busy_b;
  logic [77:0] rsp_rdata_b, din_b;
  logic [18:0] addr_b;
  logic        ceb_b, web_b, rden_b, progen_b, prog_b, erase_b, chip_b;

  logic [6:0] ctl, ctl_b;
  assign ctl   = {ceb, web, rden, progen, prog, erase, chip};
  assign ctl_b = {ceb_b, web_b, rden_b, progen_b, prog_b, erase_b, chip_b};

  localparam logic [6:0] C_IDLE   = 7'b1100000;
  localparam logic [6:0] C_RD_ISS = 7'b0110000;
  localparam logic [6:0] C_RD_WT  = 7'b0100000;
  localparam logic [6:0] C_PG     = 7'b0101000;
  localparam logic [6:0] C_PULSE  = 7'b0001100;
  localparam logic [6:0] C_ER_CH  = 7'b0101011;
  localparam logic [6:0] C_ER_SEC = 7'b0101010;

  // Macro read model: DOUT is valid in the cycle two cycles after RDEN.
  logic r1 = 1'b0, r2 = 1'b0;
  always @(posedge clk) begin
    r1 <= rden;
    r2 <= r1;
  end
  assign dout = r2 ? rd_val : '0;

  udma_mram_cmd_seq #(.READ_LAT(2)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_ec_o(rsp_ec), .rsp_ue_o(rsp_ue), .busy_o(busy),
    .mram_CEb_o(ceb), .mram_WEb_o(web), .mram_RDEN_o(rden), .mram_PROGEN_o(progen),
    .mram_PROG_o(prog), .mram_ERASE_o(erase), .mram_CHIP_o(chip),
    .mram_A_o(addr), .mram_DIN_o(din), .mram_DOUT_i(dout),
    .mram_RDY_i(rdy), .mram_DONE_i(done), .mram_EC_i(ec_in), .mram_UE_i(ue_in)
  );

  udma_mram_cmd_seq #(.READ_LAT(2), .TIMEOUT_CYC(20'd16)) dut_b (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_b),
    .rsp_err_o(rsp_err_b), .rsp_ec_o(rsp_ec_b), .rsp_ue_o(rsp_ue_b), .busy_o(busy_b),
    .mram_CEb_o(ceb_b), .mram_WEb_o(web_b), .mram_RDEN_o(rden_b), .mram_PROGEN_o(progen_b),
    .mram_PROG_o(prog_b), .mram_ERASE_o(erase_b), .mram_CHIP_o(chip_b),
    .mram_A_o(addr_b), .mram_DIN_o(din_b), .mram_DOUT_i(dout),
    .mram_RDY_i(rdy), .mram_DONE_i(done), .mram_EC_i(ec_in), .mram_UE_i(ue_in)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic ok;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0; req_op = 2'b00;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; rdy = 1'b1; done = 1'b0;
    ec_in = 1'b0; ue_in = 1'b0; rd_val = '0;
    step(); step();

    // Reset state
    chk("rst_ctl", ctl, C_IDLE);
    chk("rst_addr", addr, 19'h0);
    chk("rst_din", din, 78'h0);
    chk("rst_rsp_flags", {rsp_valid, rsp_err, rsp_ec, rsp_ue, busy}, 5'b0);
    chk("rst_rdata", rsp_rdata, 78'h0);
    chk("rst_req_ready", req_ready, 1'b1);
    rstn = 1'b1;

    // RDY low blocks acceptance
    rdy = 1'b0; req_valid = 1'b1;
    #1 chk("rdy_low_ready", req_ready, 1'b0);
    step();
    chk("rdy_low_no_accept", {busy, ctl}, {1'b0, C_IDLE});
    req_valid = 1'b0; rdy = 1'b1;

    // Read, READ_LAT=2
    req_op = 2'b00; req_addr = 19'h1234; rd_val = 78'h3A5A5; req_valid = 1'b1;
    step();
    chk("rd_issue_ctl", ctl, C_RD_ISS);
    chk("rd_issue_addr", addr, 19'h1234);
    chk("rd_issue_busy_ready", {busy, req_ready}, 2'b10);
    req_valid = 1'b0;
    step();
    chk("rd_wait_ctl", ctl, C_RD_WT);
    step();
    chk("rd_edge2_valid", rsp_valid, 1'b0);
    step();
    chk("rd_edge3_valid", rsp_valid, 1'b1);
    chk("rd_rdata", rsp_rdata, 78'h3A5A5);
    chk("rd_err_ec_ue", {rsp_err, rsp_ec, rsp_ue}, 3'b000);
    chk("rd_resp_ctl", ctl, C_IDLE);
    rsp_handshake();
    chk("rd_back_idle", {rsp_valid, busy, req_ready}, 3'b001);

    // Program, DONE sampled 50 cycles after the PROG pulse
    req_op = 2'b01; req_addr = 19'h00010; req_wdata = {78{1'b1}}; req_valid = 1'b1;
    step();
    chk("pg_setup_ctl", ctl, C_PG);
    chk("pg_din", din, {78{1'b1}});
    chk("pg_addr", addr, 19'h00010);
    req_valid = 1'b0;
    step();
    chk("pg_pulse_ctl", ctl, C_PULSE);
    step();
    chk("pg_wait_ctl", ctl, C_PG);
    ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step();
      if (ctl !== C_PG || rsp_valid !== 1'b0) ok = 1'b0;
    end
    chk("pg_progen_held", ok, 1'b1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("pg_rsp_valid", rsp_valid, 1'b1);
    chk("pg_rdata_zero", rsp_rdata, 78'h0);
    chk("pg_err", rsp_err, 1'b0);
    chk("pg_resp_ctl", ctl, C_IDLE);
    rsp_handshake();
    chk("pg_back_idle", busy, 1'b0);

    // Backpressure with a second request pending
    req_op = 2'b00; req_addr = 19'h0ABCD; rd_val = 78'h2_1234_5678_9ABC_DEF0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    chk("bp_rdata", rsp_rdata, 78'h2_1234_5678_9ABC_DEF0);
    rd_val = 78'h55; req_addr = 19'h00777; req_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_rdata !== 78'h2_1234_5678_9ABC_DEF0 ||
          req_ready !== 1'b0 || busy !== 1'b1 || ctl !== C_IDLE) ok = 1'b0;
    end
    chk("bp_stable", ok, 1'b1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_ready_after_hs", {rsp_valid, busy, req_ready}, 3'b001);
    step();
    chk("bp_next_issue_ctl", ctl, C_RD_ISS);
    chk("bp_next_addr", addr, 19'h00777);
    req_valid = 1'b0;
    step(); step(); step();
    chk("bp_next_rdata", {rsp_valid, rsp_rdata}, {1'b1, 78'h55});
    rsp_handshake();

    // Reset during PG_WAIT
    req_op = 2'b01; req_addr = 19'h00020; req_wdata = 78'h123; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step(); step(); step();
    chk("rstpg_in_wait", ctl, C_PG);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rstpg_ctl_idle", ctl, C_IDLE);
    chk("rstpg_flags", {rsp_valid, busy}, 2'b00);
    chk("rstpg_addr", addr, 19'h0);
    done = 1'b1;
    step(); step();
    done = 1'b0;
    chk("rstpg_no_rsp", rsp_valid, 1'b0);
    req_op = 2'b00; req_addr = 19'h04321; rd_val = 78'hBEEF; req_valid = 1'b1;
    step();
    chk("rstpg_rd_issue", ctl, C_RD_ISS);
    req_valid = 1'b0;
    step(); step(); step();
    chk("rstpg_rd_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 78'hBEEF});
    rsp_handshake();

    // Read with EC/UE asserted at capture, max address, all-ones data
    ec_in = 1'b1; ue_in = 1'b1;
    req_op = 2'b00; req_addr = 19'h7FFFF; rd_val = {78{1'b1}}; req_valid = 1'b1;
    step();
    chk("ue_addr", addr, 19'h7FFFF);
    req_valid = 1'b0;
    step(); step(); step();
    chk("ue_rdata", rsp_rdata, {78{1'b1}});
`ifdef MRAM_ECC_STATUS_EN
    chk("ue_err_ec_ue", {rsp_err, rsp_ec, rsp_ue}, 3'b111);
`else
    chk("ue_err_ec_ue", {rsp_err, rsp_ec, rsp_ue}, 3'b000);
`endif
    ec_in = 1'b0; ue_in = 1'b0;
    rsp_handshake();

    // Chip erase timing out after 16 wait cycles (dut_b)
    req_op = 2'b11; req_addr = 19'h00040; req_valid_b = 1'b1;
    step();
    chk("ce_pulse_ctl", ctl_b, C_ER_CH);
    req_valid_b = 1'b0;
    step();
    chk("ce_wait_ctl", ctl_b, C_PG);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid_b !== 1'b0 || ctl_b !== C_PG) ok = 1'b0;
    end
    chk("ce_wait_held", ok, 1'b1);
    step();
    chk("ce_timeout_rsp", {rsp_valid_b, rsp_err_b}, 2'b11);
    chk("ce_timeout_ctl", ctl_b, C_IDLE);
    chk("ce_timeout_rdata", rsp_rdata_b, 78'h0);
    chk("ce_dut_a_untouched", {busy, ctl}, {1'b0, C_IDLE});
    rsp_handshake();
    chk("ce_back_idle", busy_b, 1'b0);

    // Sector erase with DONE on the expiry cycle: success wins (dut_b)
    req_op = 2'b10; req_addr = 19'h00080; req_valid_b = 1'b1;
    step();
    chk("se_pulse_ctl", ctl_b, C_ER_SEC);
    req_valid_b = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("se_not_yet", rsp_valid_b, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("se_done_vs_timeout", {rsp_valid_b, rsp_err_b}, 2'b10);
    rsp_handshake();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
